// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter.
//   arb_state_t : arbiter FSM states (IDLE = grants open, COOLDOWN = hold-off)
//   idx_width() : width of a requester index for a given requester count
package reg_arb_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      COOLDOWN = 1'b1
   } arb_state_t;

   // Requester counts below 2 still need a one-bit index field.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin priority search.
//   req_valid : pending-request vector
//   rr_ptr    : index of the last accepted requester; the search starts one above it
//   grant     : one-hot winner (all zero when nothing is pending)
//   winner    : binary index of the winner
//   any_grant : high when some requester won
module rr_picker
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   winner,
   output logic               any_grant
);

   always_comb begin
      logic [IDX_W-1:0] idx;
      grant     = '0;
      winner    = '0;
      any_grant = 1'b0;
      idx       = '0;
      // Offsets 1..NUM_REQ visit every requester once, the previous winner last.
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
         if (!any_grant && req_valid[idx]) begin
            grant[idx] = 1'b1;
            winner     = idx;
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbitrated shared storage register with post-write cooldown.
//   clk, reset : clock and synchronous active-high reset
//   req_valid  : per-requester write pending
//   req_data   : requester i data in [i*DATA_W +: DATA_W]
//   req_ready  : one-hot grant, only while IDLE
//   clr        : synchronous clear of the stored value (state untouched)
//   q, q_valid : stored value and "written since reset/clr" flag
//   grant_id   : index of the last accepted requester
//   busy       : high while the cooldown is running
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int DATA_W      = 8,
   parameter  int HOLD_CYCLES = 2,
   localparam int IDX_W       = idx_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      clr,
   output logic [DATA_W-1:0]         q,
   output logic                      q_valid,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy
);

   localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES);

   arb_state_t         state, state_nxt;
   logic [3:0]         cnt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   pick_winner;
   logic               pick_any;
   logic               accept;
   logic [DATA_W-1:0]  sel_data;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (pick_grant),
      .winner    (pick_winner),
      .any_grant (pick_any)
   );

   // A winner exists only among valid requesters, so a grant in IDLE is an accept.
   assign accept = (state == IDLE) && pick_any;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_winner == IDX_W'(i)) begin
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register and cooldown counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= HOLD_LD;
         end else if (state == COOLDOWN) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && (HOLD_CYCLES > 0)) begin
               state_nxt = COOLDOWN;
            end
         end
         COOLDOWN: begin
            if (cnt <= 4'd1) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      busy      = (state == COOLDOWN);
      req_ready = (state == IDLE) ? pick_grant : '0;
   end

   // Storage register; clr overrides the data write but not the handshake bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         q        <= '0;
         q_valid  <= 1'b0;
         grant_id <= '0;
         rr_ptr   <= IDX_W'(NUM_REQ - 1);
      end else begin
         if (accept) begin
            grant_id <= pick_winner;
            rr_ptr   <= pick_winner;
         end
         if (clr) begin
            q       <= '0;
            q_valid <= 1'b0;
         end else if (accept) begin
            q       <= sel_data;
            q_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: stimulus pushes expected accepts into
// per-DUT queues, monitors pop and compare on every observed grant.
module tb_reg_write_arbiter;

   typedef struct packed {
      logic [3:0] rdy;
      logic [7:0] q;
      logic       qv;
      logic [1:0] gid;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, clr;
   logic [3:0]  va, vb;
   logic [31:0] data;
   logic [3:0]  rdy_a, rdy_b;
   logic [7:0]  q_a, q_b;
   logic        qv_a, qv_b, busy_a, busy_b;
   logic [1:0]  gid_a, gid_b;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   reg_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .req_valid(va), .req_data(data), .req_ready(rdy_a),
      .clr(clr), .q(q_a), .q_valid(qv_a), .grant_id(gid_a), .busy(busy_a));

   reg_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .req_valid(vb), .req_data(data), .req_ready(rdy_b),
      .clr(clr), .q(q_b), .q_valid(qv_b), .grant_id(gid_b), .busy(busy_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [3:0] r, input logic [7:0] qq, input logic v, input logic [1:0] g);
      exp_a.push_back('{rdy: r, q: qq, qv: v, gid: g});
   endtask

   task automatic push_b(input logic [3:0] r, input logic [7:0] qq, input logic v, input logic [1:0] g);
      exp_b.push_back('{rdy: r, q: qq, qv: v, gid: g});
   endtask

   // Monitor for the HOLD_CYCLES=2 instance.
   initial begin
      exp_t pe;
      logic pend;
      pend = 1'b0;
      pe   = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("a_q", q_a, pe.q);
            chk("a_q_valid", qv_a, pe.qv);
            chk("a_grant_id", gid_a, pe.gid);
            pend = 1'b0;
         end
         if (rdy_a != 4'b0) begin
            if (exp_a.size() == 0) begin
               chk("a_unexpected_ready", rdy_a, 0);
            end else begin
               pe = exp_a.pop_front();
               chk("a_ready", rdy_a, pe.rdy);
               pend = 1'b1;
            end
         end
      end
   end

   // Monitor for the HOLD_CYCLES=0 instance.
   initial begin
      exp_t pe;
      logic pend;
      pend = 1'b0;
      pe   = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("b_q", q_b, pe.q);
            chk("b_q_valid", qv_b, pe.qv);
            chk("b_grant_id", gid_b, pe.gid);
            pend = 1'b0;
         end
         if (rdy_b != 4'b0) begin
            if (exp_b.size() == 0) begin
               chk("b_unexpected_ready", rdy_b, 0);
            end else begin
               pe = exp_b.pop_front();
               chk("b_ready", rdy_b, pe.rdy);
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; clr = 1'b0; va = '0; vb = '0; data = '0;
      cyc(); cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_q", q_a, 0);
      chk("rst_q_valid", qv_a, 0);
      chk("rst_grant_id", gid_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_ready", rdy_a, 0);

      // Single request from 0, cooldown of two cycles with valid still held.
      cyc();
      data[7:0] = 8'hA5; va = 4'b0001;
      push_a(4'b0001, 8'hA5, 1'b1, 2'd0);
      @(negedge clk);
      cyc();
      @(negedge clk);
      chk("t1_busy_c1", busy_a, 1);
      chk("t1_ready_c1", rdy_a, 0);
      cyc();
      @(negedge clk);
      chk("t1_busy_c2", busy_a, 1);
      chk("t1_ready_c2", rdy_a, 0);
      cyc();
      va = 4'b0000;
      @(negedge clk);
      chk("t1_busy_done", busy_a, 0);

      // All four requesting from reset: order 0,1,2,3,0 three cycles apart.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      data = {8'h13, 8'h12, 8'h11, 8'h10};
      va = 4'b1111;
      push_a(4'b0001, 8'h10, 1'b1, 2'd0);
      push_a(4'b0010, 8'h11, 1'b1, 2'd1);
      push_a(4'b0100, 8'h12, 1'b1, 2'd2);
      push_a(4'b1000, 8'h13, 1'b1, 2'd3);
      push_a(4'b0001, 8'h10, 1'b1, 2'd0);
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         if (k % 3 != 0) begin
            chk("t2_ready_gap", rdy_a, 0);
            chk("t2_busy_gap", busy_a, 1);
         end
         cyc();
      end
      va = 4'b0000;

      // Set rr_ptr to 1, then requesters 1 and 3: 3 wins first.
      cyc(); cyc();
      data[15:8] = 8'h21; va = 4'b0010;
      push_a(4'b0010, 8'h21, 1'b1, 2'd1);
      @(negedge clk);
      cyc();
      va = 4'b0000;
      cyc(); cyc();
      data[15:8] = 8'h31; data[31:24] = 8'h33; va = 4'b1010;
      push_a(4'b1000, 8'h33, 1'b1, 2'd3);
      push_a(4'b0010, 8'h31, 1'b1, 2'd1);
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         chk("t3_no_ready_0_2", rdy_a & 4'b0101, 0);
         cyc();
         if (k == 0) va = 4'b0010;
      end
      va = 4'b0000;

      // clr together with accept of requester 2: write dropped, handshake kept.
      cyc(); cyc();
      data[23:16] = 8'h77; va = 4'b0100; clr = 1'b1;
      push_a(4'b0100, 8'h00, 1'b0, 2'd2);
      @(negedge clk);
      cyc();
      clr = 1'b0; data[31:24] = 8'h43; va = 4'b1111;
      push_a(4'b1000, 8'h43, 1'b1, 2'd3);
      @(negedge clk);
      chk("t4_busy_after_clr", busy_a, 1);
      cyc();
      @(negedge clk);
      cyc();
      @(negedge clk);
      cyc();

      // reset during the second cooldown cycle, all still requesting.
      @(negedge clk);
      chk("t5_busy_c1", busy_a, 1);
      cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("t5_busy_c2", busy_a, 1);
      cyc();
      reset = 1'b0;
      data[7:0] = 8'h50;
      push_a(4'b0001, 8'h50, 1'b1, 2'd0);
      @(negedge clk);
      chk("t5_busy", busy_a, 0);
      chk("t5_q", q_a, 0);
      chk("t5_q_valid", qv_a, 0);
      chk("t5_grant_id", gid_a, 0);
      chk("t5_ready_req0", rdy_a, 4'b0001);
      cyc();
      va = 4'b0000;
      @(negedge clk);
      cyc(); cyc();

      // HOLD_CYCLES=0: requester 1 granted every cycle, never busy.
      data[15:8] = 8'h60; vb = 4'b0010;
      push_b(4'b0010, 8'h60, 1'b1, 2'd1);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("t6_busy", busy_b, 0);
         chk("t6_ready", rdy_b, 4'b0010);
         cyc();
         if (k < 4) begin
            data[15:8] = 8'(8'h61 + k);
            push_b(4'b0010, 8'(8'h61 + k), 1'b1, 2'd1);
         end else begin
            vb = 4'b0000;
         end
      end
      @(negedge clk);
      chk("t6_busy_end", busy_b, 0);
      cyc(); cyc();

      chk("a_expected_left", exp_a.size(), 0);
      chk("b_expected_left", exp_b.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one DATA_W-bit storage register (a bank of D flip-flops) between NUM_REQ requesters.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Enforces a programmable cooldown after every write before the next grant.
- Sits in front of shared status/config registers so multiple masters can update them without collisions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, width of stored register and request data
- HOLD_CYCLES, 2, idle cycles enforced after each accepted write (0..15; 0 = back-to-back grants allowed)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  bit i = requester i has a write pending
- req_data  input  NUM_REQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant; bit i high = requester i accepted this cycle
- clr  input  1  synchronous clear of stored register
- q  output  DATA_W  stored register value
- q_valid  output  1  high once q has been written since reset/clr
- grant_id  output  $clog2(NUM_REQ)  index of last requester whose write was accepted
- busy  output  1  high while in COOLDOWN

Behaviour:
- Reset is synchronous, active-high, sampled on rising clk. In the reset cycle's following state:
  - q=0, q_valid=0, grant_id=0, busy=0, req_ready=0
  - state=IDLE, rr pointer=NUM_REQ-1, so requester 0 has top priority first.
- States:
  - IDLE: arbitration open.
  - COOLDOWN: counter counts HOLD_CYCLES down to 1. No grants; req_ready=0.
- Arbitration (IDLE only, combinational req_ready):
  - Search req_valid starting at index rr_ptr+1, wrapping modulo NUM_REQ.
  - The first set bit wins; req_ready is one-hot on the winner. All-zero req_valid gives req_ready=0.
- Handshake: a write is accepted when req_valid[i] & req_ready[i]. On the next edge:
  - q <= req_data slice i; q_valid<=1; grant_id<=i; rr_ptr<=i.
  - Latency: request to q update is 1 cycle.
- State transitions after accept:
  - HOLD_CYCLES>0: go to COOLDOWN with counter=HOLD_CYCLES; busy=1.
  - HOLD_CYCLES=0: stay in IDLE; a grant is possible on the very next cycle.
- COOLDOWN: counter decrements each cycle. When counter==1, the next state is IDLE and busy drops. Exactly HOLD_CYCLES cycles have no ready.
- Requesters hold req_valid and data until they see ready. Dropping valid without ready is legal; no grant is remembered.
- Non-winning requesters keep priority order; rr_ptr changes only on accept.
- clr:
  - Sets q=0 and q_valid=0 next edge, from any state.
  - clr with an accept in the same cycle: clr wins. q=0, q_valid=0, and the write is discarded.
  - The handshake still completes: grant_id and rr_ptr update and cooldown still starts. The requester is not stalled.
- clr does not affect state, counter or rr_ptr.
- reset mid-COOLDOWN: returns to IDLE with all reset values the next cycle; the counter is discarded.
- Single requester: gets every grant, spaced HOLD_CYCLES+1 cycles apart.
- grant_id stays stable until the next accept. It is unaffected by clr.

Decomposition:
- Package reg_arb_pkg holds:
  - typedef enum logic {IDLE, COOLDOWN} arb_state_t
  - localparam function for index width $clog2(NUM_REQ)
- Sub-module rr_picker: combinational round-robin priority search. Inputs req_valid and rr_ptr; outputs one-hot grant, winner index and any_grant. Instanced once.
- FSM, counter and storage register live in the top module.

Test Plan:
- Reset, then req_valid=4'b0001, data0=8'hA5 → req_ready=0001 same cycle; next cycle q=A5, q_valid=1, grant_id=0, busy=1 for 2 cycles; req_ready=0 during those cycles.
- All four valid continuously, data i = 8'h10+i → grant order 0,1,2,3,0 with accepts spaced 3 cycles apart; q sequence 10,11,12,13,10.
- Requesters 1 and 3 valid, rr_ptr=1 → 3 granted first, then 1 after cooldown; 0 and 2 never get ready.
- clr asserted in the same cycle as accept of req 2 (data 8'h77) → q=0, q_valid=0, grant_id=2, busy=1; next grant goes to requester 3 first.
- reset asserted during 2nd COOLDOWN cycle → next cycle busy=0, q=0, q_valid=0, grant_id=0; with all valid, requester 0 is granted immediately.
- HOLD_CYCLES=0 build, req 1 valid continuously → req_ready[1]=1 every cycle; q updates every cycle; busy never asserts.
